// File: rtl/mux_rr_n.sv
// N-channel round-robin streaming mux with burst stickiness and a burst-length cap.
// Optional MUX_STATS_EN adds a 16-bit forwarded-word counter on words_out_c.
module mux_rr_n #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] data_in_c,
    input  logic [NUM_CH-1:0]        valid_in_c,
    input  logic                     pause_c,
    output logic [NUM_CH-1:0]        pop_c,
    output logic [DATA_W-1:0]        data_out_c,
    output logic                     valid_out_c,
    output logic [CH_W-1:0]          active_ch_c
`ifdef MUX_STATS_EN
    ,
    output logic [15:0]              words_out_c
`endif
);

    localparam int unsigned  IDX_W     = CH_W + 1;
    localparam logic [7:0]   BURST_MAX = 8'(MAX_BURST);
    localparam logic [CH_W-1:0] LAST_RST = CH_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } state_t;

    state_t             st_q, st_d;
    logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]    last_ch_q, last_ch_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;

    logic [CH_W-1:0]    search_base;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic [CH_W-1:0]    win;
    logic               other_valid;
    logic               cur_valid;
    logic               take;
    logic [CH_W-1:0]    take_ch;
    logic [NUM_CH-1:0]  pop_d;
    logic [DATA_W-1:0]  data_sel;

    // Round-robin search starting just after the base channel, ending on it.
    always_comb begin
        search_base = (st_q == IDLE) ? last_ch_q : cur_ch_q;
        idx         = '0;
        found       = 1'b0;
        win         = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            idx = {1'b0, search_base} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_CH)) begin
                idx = idx - IDX_W'(NUM_CH);
            end
            if (!found && valid_in_c[idx[CH_W-1:0]]) begin
                found = 1'b1;
                win   = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        other_valid = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (valid_in_c[i] && (CH_W'(i) != cur_ch_q)) begin
                other_valid = 1'b1;
            end
        end
        cur_valid = valid_in_c[cur_ch_q];
    end

    // Next-state and grant decision.
    always_comb begin
        st_d        = st_q;
        cur_ch_d    = cur_ch_q;
        last_ch_d   = last_ch_q;
        burst_cnt_d = burst_cnt_q;
        take        = 1'b0;
        take_ch     = cur_ch_q;
        if (!pause_c) begin
            case (st_q)
                IDLE: begin
                    if (found) begin
                        take        = 1'b1;
                        take_ch     = win;
                        st_d        = TRANS;
                        cur_ch_d    = win;
                        burst_cnt_d = 8'd1;
                    end
                end
                TRANS: begin
                    if (cur_valid && ((burst_cnt_q < BURST_MAX) || !other_valid)) begin
                        take    = 1'b1;
                        take_ch = cur_ch_q;
                        if (burst_cnt_q < BURST_MAX) begin
                            burst_cnt_d = burst_cnt_q + 8'd1;
                        end
                    end else begin
                        // Handover searched from cur_ch so the switch costs no bubble.
                        last_ch_d = cur_ch_q;
                        if (found) begin
                            take        = 1'b1;
                            take_ch     = win;
                            cur_ch_d    = win;
                            burst_cnt_d = 8'd1;
                        end else begin
                            st_d = IDLE;
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pop_d    = '0;
        data_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (take_ch == CH_W'(i)) begin
                pop_d[i] = take;
                data_sel = data_in_c[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= IDLE;
            cur_ch_q    <= '0;
            last_ch_q   <= LAST_RST;
            burst_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            cur_ch_q    <= cur_ch_d;
            last_ch_q   <= last_ch_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= take ? data_sel : '0;
            valid_q     <= take;
        end
    end

    assign pop_c       = reset ? '0 : pop_d;
    assign data_out_c  = data_q;
    assign valid_out_c = valid_q;
    assign active_ch_c = cur_ch_q;

`ifdef MUX_STATS_EN
    logic [15:0] words_q;

    // Wrapping count of words presented on the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_q <= '0;
        end else if (valid_q) begin
            words_q <= words_q + 16'd1;
        end
    end

    assign words_out_c = words_q;
`else
    // Statistics counter not built.
`endif

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n (NUM_CH=4, DATA_W=8, MAX_BURST=4) with directed grant sequences.
module tb_mux_rr_n;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [1:0] ch;
    } rec_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] data_in_c;
    logic [NUM_CH-1:0]        valid_in_c;
    logic                     pause_c;
    logic [NUM_CH-1:0]        pop_c;
    logic [DATA_W-1:0]        data_out_c;
    logic                     valid_out_c;
    logic [1:0]               active_ch_c;
`ifdef MUX_STATS_EN
    logic [15:0]              words_out_c;
`endif

    logic [7:0] head [NUM_CH];
    rec_t       exp_q [$];
    int         checks   = 0;
    int         failures = 0;

    mux_rr_n #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in_c   (data_in_c),
        .valid_in_c  (valid_in_c),
        .pause_c     (pause_c),
        .pop_c       (pop_c),
        .data_out_c  (data_out_c),
        .valid_out_c (valid_out_c),
        .active_ch_c (active_ch_c)
`ifdef MUX_STATS_EN
        ,
        .words_out_c (words_out_c)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            data_in_c[i*DATA_W +: DATA_W] = head[i];
        end
    end

    // Monitor: compare each registered output cycle against the queued expectation.
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            checks++;
            if ({valid_out_c, data_out_c, active_ch_c} !== r) begin
                failures++;
                $display("FAIL out t=%0t got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                         $time, valid_out_c, data_out_c, active_ch_c, r.v, r.d, r.ch);
            end
        end
    end

    task automatic check_pop(input logic [3:0] exp_pop);
        checks++;
        if (pop_c !== exp_pop) begin
            failures++;
            $display("FAIL pop t=%0t got=%b exp=%b", $time, pop_c, exp_pop);
        end
    endtask

    // One cycle: drive inputs, check pop, queue the expected registered output.
    task automatic step(input logic [3:0] vin, input logic pse, input int exp_ch,
                        input logic [1:0] exp_act);
        logic [3:0] exp_pop;
        rec_t       r;
        valid_in_c = vin;
        pause_c    = pse;
        exp_pop    = (exp_ch >= 0) ? 4'(4'b0001 << exp_ch) : 4'b0000;
        @(negedge clk);
        check_pop(exp_pop);
        r.v  = (exp_ch >= 0);
        r.d  = (exp_ch >= 0) ? head[exp_ch] : 8'h00;
        r.ch = exp_act;
        @(posedge clk);
        #1;
        exp_q.push_back(r);
        if (exp_ch >= 0) head[exp_ch] = head[exp_ch] + 8'd1;
    endtask

    task automatic do_reset(input logic [3:0] vin);
        rec_t r;
        reset      = 1'b1;
        valid_in_c = vin;
        pause_c    = 1'b0;
        @(negedge clk);
        check_pop(4'b0000);
        r = '0;
        @(posedge clk);
        #1;
        exp_q.push_back(r);
        reset = 1'b0;
    endtask

    task automatic set_heads();
        head[0] = 8'hA0;
        head[1] = 8'hB0;
        head[2] = 8'hC0;
        head[3] = 8'hD0;
    endtask

    initial begin
        set_heads();
        valid_in_c = '0;
        pause_c    = 1'b0;

        // Alternating bursts of four between ch0 and ch2.
        do_reset(4'b0101);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (r == 1) step(4'b0101, 1'b0, 2, 2'd2);
                else        step(4'b0101, 1'b0, 0, 2'd0);
            end
        end

        // Sole valid channel streams past the cap without gaps.
        set_heads();
        do_reset(4'b1000);
        for (int k = 0; k < 40; k++) step(4'b1000, 1'b0, 3, 2'd3);

        // ch1 drops while ch2 waits: same-cycle switch.
        set_heads();
        do_reset(4'b0110);
        step(4'b0110, 1'b0, 1, 2'd1);
        step(4'b0110, 1'b0, 1, 2'd1);
        for (int k = 0; k < 3; k++) step(4'b0100, 1'b0, 2, 2'd2);

        // Pause at burst_cnt=2, resume on ch0 for two more, then ch2.
        set_heads();
        do_reset(4'b0101);
        step(4'b0101, 1'b0, 0, 2'd0);
        step(4'b0101, 1'b0, 0, 2'd0);
        for (int k = 0; k < 3; k++) step(4'b0101, 1'b1, -1, 2'd0);
        step(4'b0101, 1'b0, 0, 2'd0);
        step(4'b0101, 1'b0, 0, 2'd0);
        step(4'b0101, 1'b0, 2, 2'd2);

        // Reset in the middle of a ch2 burst; ch0 wins first afterwards.
        set_heads();
        do_reset(4'b0100);
        step(4'b0100, 1'b0, 2, 2'd2);
        step(4'b0100, 1'b0, 2, 2'd2);
        do_reset(4'b1111);
        for (int k = 0; k < 4; k++) step(4'b1111, 1'b0, 0, 2'd0);
        step(4'b1111, 1'b0, 1, 2'd1);

`ifdef MUX_STATS_EN
        // Counter wraps: 0x10005 forwarded words leave 0x0005.
        set_heads();
        do_reset(4'b0001);
        for (int k = 0; k < 32'h10005; k++) step(4'b0001, 1'b0, 0, 2'd0);
        step(4'b0000, 1'b0, -1, 2'd0);
        checks++;
        if (words_out_c !== 16'h0005) begin
            failures++;
            $display("FAIL words got=%h exp=0005", words_out_c);
        end
`endif

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
